// File: rtl/btn_conditioner.sv
// btn_conditioner: four-channel button front end for the game controller.
// Synchronises raw buttons, debounces them on the 100 Hz tick, and emits one
// press pulse per debounced press. Each pulse is held for a full tick period.
// Optional build macro: BTN_LOCKOUT_EN limits output to one press pulse per
// tick period. Lowest index wins, and any press is blocked while a level is set.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100hz,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_p,
  output logic       btn_any_p,
  output logic [3:0] btn_level
);

  localparam int         NumBtn  = 4;
  localparam logic [3:0] CntLast = 4'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StPress, StHeld, StRel} state_e;

  logic [3:0] sync1_q, sync2_q;
  state_e     state_q [NumBtn];
  state_e     state_d [NumBtn];
  logic [3:0] cnt_q   [NumBtn];
  logic [3:0] cnt_d   [NumBtn];
  logic [3:0] level_q, level_d;
  logic [3:0] press_ev;
  logic [3:0] grant;
  logic [3:0] btn_p_q, btn_p_d;
  logic       any_q, any_d;

  // Two-flop synchroniser; polarity is fixed before the first flop so reset means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw ^ {4{ACTIVE_LOW}};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce FSM next state; advances only on tick cycles.
  always_comb begin
    level_d  = level_q;
    press_ev = '0;
    for (int i = 0; i < NumBtn; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_100hz) begin
        unique case (state_q[i])
          StIdle: begin
            if (sync2_q[i]) begin
              state_d[i] = StPress;
              cnt_d[i]   = 4'd1;
            end
          end
          StPress: begin
            if (!sync2_q[i]) begin
              state_d[i] = StIdle;
              cnt_d[i]   = 4'd0;
            end else if (cnt_q[i] == CntLast) begin
              state_d[i]  = StHeld;
              cnt_d[i]    = 4'd0;
              level_d[i]  = 1'b1;
              press_ev[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
          StHeld: begin
            if (!sync2_q[i]) begin
              state_d[i] = StRel;
              cnt_d[i]   = 4'd1;
            end
          end
          StRel: begin
            if (sync2_q[i]) begin
              // Bounce during release: back to held without a new event.
              state_d[i] = StHeld;
              cnt_d[i]   = 4'd0;
            end else if (cnt_q[i] == CntLast) begin
              state_d[i] = StIdle;
              cnt_d[i]   = 4'd0;
              level_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = 4'd0;
          end
        endcase
      end
    end
  end

  // Decide which press events become pulses.
  always_comb begin
`ifdef BTN_LOCKOUT_EN
    // Isolate the lowest set event bit; suppress everything while any level is held.
    grant = (level_q == 4'b0000) ? (press_ev & (~press_ev + 4'd1)) : 4'b0000;
`else
    grant = press_ev;
`endif
  end

  // Pulses are re-evaluated only on ticks, so each lasts exactly one tick period.
  always_comb begin
    btn_p_d = tick_100hz ? grant  : btn_p_q;
    any_d   = tick_100hz ? |grant : any_q;
  end

  // State, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= 4'd0;
      end
      level_q <= '0;
      btn_p_q <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      btn_p_q <= btn_p_d;
      any_q   <= any_d;
    end
  end

  assign btn_p     = btn_p_q;
  assign btn_any_p = any_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table-driven bench for btn_conditioner, DEBOUNCE_TICKS=3,
// one tick every 10 clk. A second instance covers ACTIVE_LOW=1.
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] btn_raw;
  logic [3:0] btn_p;
  logic       btn_any_p;
  logic [3:0] btn_level;
  logic [3:0] btn_raw_al;
  logic [3:0] al_p;
  logic       al_any;
  logic [3:0] al_level;

  btn_conditioner #(
    .DEBOUNCE_TICKS(3),
    .ACTIVE_LOW    (1'b0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_100hz(tick),
    .btn_raw   (btn_raw),
    .btn_p     (btn_p),
    .btn_any_p (btn_any_p),
    .btn_level (btn_level)
  );

  btn_conditioner #(
    .DEBOUNCE_TICKS(3),
    .ACTIVE_LOW    (1'b1)
  ) u_dut_al (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_100hz(tick),
    .btn_raw   (btn_raw_al),
    .btn_p     (al_p),
    .btn_any_p (al_any),
    .btn_level (al_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BTN_LOCKOUT_EN
  localparam logic [3:0] SimP = 4'b0010;  // simultaneous 1 and 3: lowest wins
  localparam logic [3:0] SupP = 4'b0000;  // press while another level held
`else
  localparam logic [3:0] SimP = 4'b1010;
  localparam logic [3:0] SupP = 4'b1000;
`endif

  typedef struct {
    logic [3:0] raw;
    logic [3:0] p;    // btn_p just after this period's tick
    logic [3:0] lvl;  // btn_level just after this period's tick
  } vec_t;

  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] prev_p;
  logic [3:0] mid_p, tick_p, post_p, post_l;
  logic       tick_any, post_any;
  logic [3:0] post_al_p, post_al_l;
  logic       post_al_any;
  logic [3:0] al_seen;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] raw, input logic [3:0] p, input logic [3:0] lvl);
    vec_t v;
    v.raw = raw;
    v.p   = p;
    v.lvl = lvl;
    tbl.push_back(v);
  endtask

  // One tick period, entered 1 time unit after a rising edge: 9 idle clk, then a tick clk.
  task automatic period(input logic [3:0] raw, input logic [3:0] raw_al);
    btn_raw    = raw;
    btn_raw_al = raw_al;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) mid_p = btn_p;
      al_seen = al_seen | al_p | {3'b000, al_any};
    end
    tick = 1'b1;
    @(negedge clk);
    tick_p   = btn_p;       // what a tick-sampling consumer sees
    tick_any = btn_any_p;
    @(posedge clk);
    #1;
    tick        = 1'b0;
    post_p      = btn_p;
    post_l      = btn_level;
    post_any    = btn_any_p;
    post_al_p   = al_p;
    post_al_l   = al_level;
    post_al_any = al_any;
  endtask

  // Check one period of the main instance against expected post-tick values.
  task automatic run_check(input string tag, input logic [3:0] raw, input logic [3:0] p,
                           input logic [3:0] lvl);
    period(raw, 4'hF);
    check({tag, " p_mid"}, mid_p, prev_p);
    check({tag, " p_tick"}, tick_p, prev_p);
    check({tag, " any_tick"}, {3'b000, tick_any}, {3'b000, |prev_p});
    check({tag, " p"}, post_p, p);
    check({tag, " level"}, post_l, lvl);
    check({tag, " any"}, {3'b000, post_any}, {3'b000, |p});
    prev_p = p;
  endtask

  initial begin
    rst_n      = 1'b0;
    tick       = 1'b0;
    btn_raw    = 4'h0;
    btn_raw_al = 4'hF;
    prev_p     = 4'h0;
    al_seen    = 4'h0;

    // Idle period
    add(4'h0, 4'h0, 4'h0);
    // Clean press of button 2, held 10 ticks
    add(4'h4, 4'h0, 4'h0);
    add(4'h4, 4'h0, 4'h0);
    add(4'h4, 4'h4, 4'h4);
    for (int k = 0; k < 7; k++) add(4'h4, 4'h0, 4'h4);
    // Short release (2 ticks) is rejected, then full release and re-press
    add(4'h0, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h4);
    add(4'h4, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h0);
    add(4'h4, 4'h0, 4'h0);
    add(4'h4, 4'h0, 4'h0);
    add(4'h4, 4'h4, 4'h4);
    add(4'h4, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h4);
    add(4'h0, 4'h0, 4'h0);
    // Bounce on button 0: high 2, low 1, high 3
    add(4'h1, 4'h0, 4'h0);
    add(4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h0, 4'h0);
    add(4'h1, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h1);
    add(4'h1, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h0);
    // Buttons 1 and 3 together
    add(4'hA, 4'h0, 4'h0);
    add(4'hA, 4'h0, 4'h0);
    add(4'hA, SimP, 4'hA);
    add(4'hA, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'h0);
    // Button 3 pressed while button 1 is already held
    add(4'h2, 4'h0, 4'h0);
    add(4'h2, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h2);
    add(4'hA, 4'h0, 4'h2);
    add(4'hA, 4'h0, 4'h2);
    add(4'hA, SupP, 4'hA);
    add(4'hA, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'hA);
    add(4'h0, 4'h0, 4'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset p", btn_p, 4'h0);
    check("reset level", btn_level, 4'h0);
    check("reset any", {3'b000, btn_any_p}, 4'h0);
    check("reset al_p", al_p, 4'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_check($sformatf("row%0d", i), tbl[i].raw, tbl[i].p, tbl[i].lvl);
    end

    // Asynchronous reset in the middle of a button-1 pulse, button still held
    run_check("rst pre0", 4'h2, 4'h0, 4'h0);
    run_check("rst pre1", 4'h2, 4'h0, 4'h0);
    run_check("rst pre2", 4'h2, 4'h2, 4'h2);
    repeat (3) @(posedge clk);
    #1;
    check("rst pulse live", btn_p, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async p", btn_p, 4'h0);
    check("rst async level", btn_level, 4'h0);
    check("rst async any", {3'b000, btn_any_p}, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    prev_p = 4'h0;
    run_check("rst post0", 4'h2, 4'h0, 4'h0);
    run_check("rst post1", 4'h2, 4'h0, 4'h0);
    run_check("rst post2", 4'h2, 4'h2, 4'h2);
    run_check("rst post3", 4'h2, 4'h0, 4'h2);
    run_check("rst rel0", 4'h0, 4'h0, 4'h2);
    run_check("rst rel1", 4'h0, 4'h0, 4'h2);
    run_check("rst rel2", 4'h0, 4'h0, 4'h0);

    // Active-low instance: idle-high inputs have produced nothing so far
    check("al idle pulses", al_seen, 4'h0);
    check("al idle level", al_level, 4'h0);
    period(4'h0, 4'hE);
    check("al press0 p", post_al_p, 4'h0);
    check("al press0 level", post_al_l, 4'h0);
    period(4'h0, 4'hE);
    check("al press1 p", post_al_p, 4'h0);
    period(4'h0, 4'hE);
    check("al press2 p", post_al_p, 4'h1);
    check("al press2 level", post_al_l, 4'h1);
    check("al press2 any", {3'b000, post_al_any}, 4'h1);
    period(4'h0, 4'hE);
    check("al press3 p", post_al_p, 4'h0);
    check("al press3 level", post_al_l, 4'h1);
    period(4'h0, 4'hF);
    period(4'h0, 4'hF);
    period(4'h0, 4'hF);
    check("al release level", post_al_l, 4'h0);
    check("al release p", post_al_p, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Four-channel button front end directly upstream of the game controller FSM. Synchronises raw board buttons, debounces them on the 100 Hz game tick, and emits exactly one press pulse per debounced press. Each pulse is held for one full tick period, so a consumer that only samples on tick_100hz cycles sees it exactly once. Also exports debounced button levels.

Parameters:
DEBOUNCE_TICKS, 3, consecutive tick samples required to accept a press or release; legal range 2..15 (30 ms default at 100 Hz)
ACTIVE_LOW, 0, 1 = raw board inputs are active-low and are inverted before synchronisation

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tick_100hz  in  1  one-clk-wide enable strobe, 100 Hz; all debounce state advances only on cycles where it is high
btn_raw  in  4  raw asynchronous button inputs, bit i = button i
btn_p  out  4  press pulses, bit i maps to consumer btn_i_p; held exactly one tick period
btn_any_p  out  1  OR of btn_p, registered in the same cycle as btn_p
btn_level  out  4  debounced pressed level, 1 = pressed

Behaviour:
- Reset (async, rst_n=0):
  - btn_p=0, btn_any_p=0, btn_level=0.
  - Synchroniser flops load the released value (0 after polarity fix).
  - All channels enter IDLE with cnt=0.
- Synchroniser: 2-flop per bit, clocked every clk. Input is btn_raw XOR {4{ACTIVE_LOW}}. The synchronised value s[i] is what the FSM samples.
- Per-channel FSM, advancing only on tick_100hz=1 cycles. On all other cycles state, cnt and outputs hold. cnt is 4 bits.
  - IDLE: s=1 -> PRESS, cnt=1. Otherwise stay.
  - PRESS: s=0 -> IDLE, cnt=0. Else if cnt==DEBOUNCE_TICKS-1 -> HELD, btn_level[i]=1, raise press event. Else cnt++.
  - HELD: s=0 -> REL, cnt=1. Otherwise stay.
  - REL: s=1 -> HELD, cnt=0, no new event. Else if cnt==DEBOUNCE_TICKS-1 -> IDLE, btn_level[i]=0. Else cnt++.
- Net effect:
  - A press is accepted on the DEBOUNCE_TICKS-th consecutive high tick sample.
  - A release is accepted on the DEBOUNCE_TICKS-th consecutive low tick sample.
  - Any bounce restarts the count.
- Pulse timing:
  - A press event at tick N sets btn_p[i]=1 from the clk after tick N.
  - At tick N+1, btn_p[i] is cleared unless a new event occurs; a new event is impossible on the same channel.
  - The consumer therefore samples btn_p[i]=1 on exactly one tick (N+1).
  - btn_any_p follows the same timing.
- Latency from a clean raw edge: 2 clk (synchroniser) plus DEBOUNCE_TICKS tick samples, plus one tick until the consumer samples.
- Holding a button produces no further pulses. A new pulse requires a full debounced release, then a new press.
- Simultaneous events: channels are independent. Multiple btn_p bits may assert in the same period; the consumer treats that as a wrong input.
- Reset mid-press or mid-pulse: outputs drop immediately (async). After reset, a button still held must be re-debounced from IDLE and does produce one pulse.
- tick_100hz stuck high: the block debounces per clk; behaviour is otherwise identical.

Optional Feature:
BTN_LOCKOUT_EN
- Defined:
  - At most one btn_p bit asserts per tick period.
  - If several channels raise press events on the same tick, the lowest index wins. The losers go to HELD with btn_level set but emit no pulse.
  - While any btn_level bit is 1, a press event on any other channel is suppressed (FSM still goes to HELD, level set, no pulse).
- Undefined: channels fully independent, as described above.

Test Plan:
Bench uses DEBOUNCE_TICKS=3 and a tick every 10 clk.
1. Reset, then clean press of btn_raw[2] held 10 ticks -> btn_level[2] rises on the 3rd tick sample. btn_p=4'b0100 for exactly one tick period (10 clk), sampled high on exactly one tick. btn_any_p matches. No further pulses while held.
2. Bounce: btn_raw[0] high 2 ticks, low 1 tick, high 3 ticks -> exactly one pulse, produced on the 3rd sample of the final high run. btn_level[0]=0 before that.
3. Release debounce: after case 1, drop btn_raw[2] for 2 ticks then re-raise -> no new pulse, btn_level stays 1. Then drop for 3 ticks and press again -> btn_level falls, then one new pulse.
4. Simultaneous: btn_raw[1] and btn_raw[3] rise on the same clk -> btn_p=4'b1010 for one tick period. With BTN_LOCKOUT_EN -> btn_p=4'b0010 and btn_level=4'b1010.
5. ACTIVE_LOW=1, btn_raw idles 4'hF -> no pulses. Driving bit 0 low for 3 ticks -> btn_p=4'b0001.
6. Assert rst_n=0 while btn_p[1]=1 -> btn_p and btn_level go 0 immediately. Release reset with button held -> one pulse after 3 ticks.
